gpio_port: RTL
==============

// Module: gpio_port
// PURPOSE
//  Parametrised memory-mapped GPIO peripheral; next generation of the 9-pin mode/data GPIO pair.
//  Adds per-pin direction, atomic set/clear/toggle, input synchroniser, edge-detect interrupts with
//  write-1-to-clear pending bits, and a registered read port. Sits on the processor I/O bus behind
//  the address-decoder write enable; its rdata feeds the DIN multiplexer.
// PARAMETERS
//  WIDTH        9   number of GPIO pins and data-bus width
//  SYNC_STAGES  2   input synchroniser depth (>=2)
// PORTS
//  clock     in     1      single system clock, rising edge
//  resetn    in     1      asynchronous, active-low reset
//  addr      in     3      register select (map below)
//  wr_en     in     1      write strobe, sampled on rising clock edge
//  wdata     in     WIDTH  write data
//  rdata     out    WIDTH  read data, registered
//  irq       out    1      interrupt request, active-high
//  gpio      inout  WIDTH  pads
// BEHAVIOUR
//  Register map (addr):
//   0 MODE   RW  1=output, 0=input (pad tri-stated)
//   1 OUT    RW  output data; pad[i] = MODE[i] ? OUT[i] : 1'bz
//   2 IN     RO  synchronised pad value, all pins incl. outputs (loopback)
//   3 SET    WO  OUT |= wdata; reads 0
//   4 CLR    WO  OUT &= ~wdata; reads 0
//   5 TGL    WO  OUT ^= wdata; reads 0
//   6 IRQ_EN RW  per-pin interrupt enable
//   7 PEND   R/W1C  pending edge flags; writing 1 clears bit, 0 no effect
//  - Reset (resetn=0, async): MODE, OUT, IRQ_EN, PEND, sync chain, edge history, rdata all 0;
//    arm counter 0; irq=0; all pads Z.
//  - Writes take effect on the clock edge where wr_en=1; writes to RO addr 2 ignored.
//  - Reads: no strobe, side-effect free; rdata <= reg[addr] every edge -> 1-cycle latency.
//    Read of a register written in the same cycle returns the OLD value.
//  - Synchroniser: SYNC_STAGES flops per pin; IN = last stage. Pad-to-IN latency SYNC_STAGES cycles.
//  - Edge detect: prev <= IN each cycle; rise[i] = IN[i] & ~prev[i].
//    PEND[i] sets on rise[i] only if MODE[i]==0 and armed; IRQ_EN does not gate setting.
//  - Arming: counter counts SYNC_STAGES+1 cycles after reset release, then armed=1 until next
//    reset; suppresses spurious edges from pads already high at reset.
//  - PEND set and W1C of same bit in same cycle: set wins (bit stays 1).
//  - irq = |(PEND & IRQ_EN), from registers only (glitch-free); asserted the cycle after the edge.
//  - MODE change 0->1 mid-edge: edge seen in same cycle as MODE write still uses old MODE.
// CONFIGURATION
//  GPIO_PORT_ANY_EDGE_EN defined: PEND[i] sets on any change (IN[i] ^ prev[i]).
//  Undefined: rising edges only. Register map, latency and arming identical either way.
// TESTING
//  1 reset, write MODE=0x1FF, OUT=0x0A5 -> gpio=0x0A5; read addr1 -> rdata=0x0A5 one cycle later.
//  2 OUT=0x0F0; SET 0x003, CLR 0x010, TGL 0x101 on successive cycles -> OUT=0x1E2; reads of 3/4/5=0.
//  3 MODE=0, pad0 0->1 -> IN[0]=1 after 2 cycles, PEND=0x001 next cycle; IRQ_EN=0x001 -> irq=1;
//    write PEND=0x001 -> PEND=0, irq=0.
//  4 pad0 held 1 through reset -> PEND stays 0 after release (arming); falling edge: PEND 0
//    (ANY_EDGE undefined) / 0x001 (defined).
//  5 pad rising edge on bit 3 in same cycle as W1C 0x008 -> PEND[3]=1 (set wins).
//  6 resetn pulsed low mid-operation, no clock -> MODE/OUT/PEND/rdata=0, gpio all Z immediately.

Source files
------------

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO with per-pin direction, set/clear/toggle, synchronised inputs and
// edge-detect interrupts. Define GPIO_PORT_ANY_EDGE_EN to latch pending flags on both edges.
module gpio_port #(
  parameter int WIDTH       = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [2:0]       addr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             irq,
  inout  wire  [WIDTH-1:0] gpio
);

  localparam logic [2:0] A_MODE   = 3'd0;
  localparam logic [2:0] A_OUT    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_SET    = 3'd3;
  localparam logic [2:0] A_CLR    = 3'd4;
  localparam logic [2:0] A_TGL    = 3'd5;
  localparam logic [2:0] A_IRQ_EN = 3'd6;
  localparam logic [2:0] A_PEND   = 3'd7;

  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CW         = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] mode_q, out_q, irq_en_q, pend_q, prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_val, edge_mask, set_mask, w1c_mask, rd_val;
  logic [CW-1:0]    arm_cnt;
  logic             armed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpio[i] = mode_q[i] ? out_q[i] : 1'bz;
  end

  assign in_val = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_cnt == CW'(ARM_CYCLES));

`ifdef GPIO_PORT_ANY_EDGE_EN
  assign edge_mask = in_val ^ prev_q;
`else
  assign edge_mask = in_val & ~prev_q;
`endif

  // Only pins that were inputs before this edge may flag, and only once the sync chain has settled
  assign set_mask = armed ? (edge_mask & ~mode_q) : '0;
  assign w1c_mask = (wr_en && addr == A_PEND) ? wdata : '0;

  always_comb begin
    rd_val = '0;
    case (addr)
      A_MODE:   rd_val = mode_q;
      A_OUT:    rd_val = out_q;
      A_IN:     rd_val = in_val;
      A_IRQ_EN: rd_val = irq_en_q;
      A_PEND:   rd_val = pend_q;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q  <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q[0] <= gpio;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= in_val;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mode_q   <= '0;
      out_q    <= '0;
      irq_en_q <= '0;
      pend_q   <= '0;
      rdata    <= '0;
    end else begin
      rdata  <= rd_val;
      pend_q <= (pend_q & ~w1c_mask) | set_mask;
      if (wr_en) begin
        case (addr)
          A_MODE:   mode_q   <= wdata;
          A_OUT:    out_q    <= wdata;
          A_SET:    out_q    <= out_q | wdata;
          A_CLR:    out_q    <= out_q & ~wdata;
          A_TGL:    out_q    <= out_q ^ wdata;
          A_IRQ_EN: irq_en_q <= wdata;
          default:  ;
        endcase
      end
    end
  end

  assign irq = |(pend_q & irq_en_q);

endmodule
